// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// cpu_run_ctrl: sequences the core reset through NUM_RUNS hold/run passes.
// Each run is bounded by a cycle budget or an early halt. The controller
// watches the LED bus and reports a result, a verdict and activity counters.
module cpu_run_ctrl #(
  parameter int LED_W = 8,
  parameter int HOLD_CYCLES = 12,
  parameter int RUN_CYCLES = 1000,
  parameter int NUM_RUNS = 2,
  parameter int CNT_W = 16,
  parameter logic [LED_W-1:0] EXPECT_LED = '0,
  localparam int IDX_W = $clog2(NUM_RUNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             halt,
  input  logic [LED_W-1:0] core_led,
  output logic             core_rst,
  output logic             run_active,
  output logic             done,
  output logic             pass,
  output logic [LED_W-1:0] last_led,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [IDX_W-1:0] run_idx,
  output logic [CNT_W-1:0] led_changes
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  // The budget counter is sized from RUN_CYCLES itself, so a narrow CNT_W
  // only affects the reported count and never the length of a run.
  localparam int RC_W = $clog2(RUN_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RC_W-1:0]   RUN_LAST  = RC_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RUNS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [RC_W-1:0]    run_cnt;
  logic [LED_W-1:0]   prev_led;
  logic               run_end;
  logic               led_changed;

  // A run ends on halt or on the last budgeted cycle; both together are one end.
  assign run_end     = halt || (run_cnt == RUN_LAST);
  assign led_changed = (core_led != prev_led);

  // Previous LED value, tracked every cycle so the first RUN cycle compares
  // against the bus as it stood at the end of HOLD.
  always_ff @(posedge clk) begin
    if (rst) prev_led <= '0;
    else     prev_led <= core_led;
  end

  // Run sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      core_rst    <= 1'b1;
      run_active  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      last_led    <= '0;
      cycle_cnt   <= '0;
      run_idx     <= '0;
      led_changes <= '0;
      hold_cnt    <= '0;
      run_cnt     <= '0;
    end else if (abort) begin
      // Counters and last_led are left untouched for inspection.
      state      <= S_IDLE;
      core_rst   <= 1'b1;
      run_active <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_HOLD;
            core_rst    <= 1'b1;
            run_active  <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            run_idx     <= '0;
            led_changes <= '0;
            cycle_cnt   <= '0;
            hold_cnt    <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            core_rst   <= 1'b0;
            run_active <= 1'b1;
            cycle_cnt  <= '0;
            run_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
          run_cnt   <= run_cnt + RC_W'(1);
          if (led_changed && (led_changes != {CNT_W{1'b1}})) begin
            led_changes <= led_changes + CNT_W'(1);
          end
          if (run_end) begin
            last_led   <= core_led;
            core_rst   <= 1'b1;
            run_active <= 1'b0;
            if (run_idx == IDX_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (core_led == EXPECT_LED);
            end else begin
              state    <= S_HOLD;
              run_idx  <= run_idx + IDX_W'(1);
              hold_cnt <= '0;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
// tb_cpu_run_ctrl: directed scenarios plus randomized sequences checked
// against a per-run reference model (run length, LED history, verdict).
module tb_cpu_run_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT instances ----------------
  // u_def: default parameters
  logic d_start, d_abort, d_halt;
  logic [7:0] d_led, d_last_led;
  logic d_core_rst, d_run_active, d_done, d_pass;
  logic [15:0] d_cycle_cnt, d_led_changes;
  logic [1:0] d_run_idx;
  cpu_run_ctrl u_def (
    .clk(clk), .rst(rst), .start(d_start), .abort(d_abort), .halt(d_halt), .core_led(d_led),
    .core_rst(d_core_rst), .run_active(d_run_active), .done(d_done), .pass(d_pass),
    .last_led(d_last_led), .cycle_cnt(d_cycle_cnt), .run_idx(d_run_idx), .led_changes(d_led_changes)
  );

  // u_short: single 50-cycle run
  logic s_start, s_abort, s_halt;
  logic [7:0] s_led, s_last_led;
  logic s_core_rst, s_run_active, s_done, s_pass;
  logic [15:0] s_cycle_cnt, s_led_changes;
  logic [0:0] s_run_idx;
  cpu_run_ctrl #(.RUN_CYCLES(50), .NUM_RUNS(1)) u_short (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .halt(s_halt), .core_led(s_led),
    .core_rst(s_core_rst), .run_active(s_run_active), .done(s_done), .pass(s_pass),
    .last_led(s_last_led), .cycle_cnt(s_cycle_cnt), .run_idx(s_run_idx), .led_changes(s_led_changes)
  );

  // u_sat: narrow counters to reach saturation
  logic t_start, t_abort, t_halt;
  logic [7:0] t_led, t_last_led;
  logic t_core_rst, t_run_active, t_done, t_pass;
  logic [3:0] t_cycle_cnt, t_led_changes;
  logic [1:0] t_run_idx;
  cpu_run_ctrl #(.CNT_W(4), .RUN_CYCLES(40)) u_sat (
    .clk(clk), .rst(rst), .start(t_start), .abort(t_abort), .halt(t_halt), .core_led(t_led),
    .core_rst(t_core_rst), .run_active(t_run_active), .done(t_done), .pass(t_pass),
    .last_led(t_last_led), .cycle_cnt(t_cycle_cnt), .run_idx(t_run_idx), .led_changes(t_led_changes)
  );

  // u_rnd: short holds/runs, three passes, for random and edge scenarios
  logic r_start, r_abort, r_halt;
  logic [7:0] r_led, r_last_led;
  logic r_core_rst, r_run_active, r_done, r_pass;
  logic [4:0] r_cycle_cnt, r_led_changes;
  logic [1:0] r_run_idx;
  cpu_run_ctrl #(.HOLD_CYCLES(3), .RUN_CYCLES(20), .NUM_RUNS(3), .CNT_W(5), .EXPECT_LED(8'h3C)) u_rnd (
    .clk(clk), .rst(rst), .start(r_start), .abort(r_abort), .halt(r_halt), .core_led(r_led),
    .core_rst(r_core_rst), .run_active(r_run_active), .done(r_done), .pass(r_pass),
    .last_led(r_last_led), .cycle_cnt(r_cycle_cnt), .run_idx(r_run_idx), .led_changes(r_led_changes)
  );

  // ---------------- helpers (measurement only) ----------------
  // Counts consecutive cycles with core_rst at lvl, starting at the current negedge.
  task automatic count_level(input int sel, input logic lvl, input int limit, output int n);
    n = 0;
    while ((((sel == 0) ? d_core_rst : r_core_rst) === lvl) && (n < limit)) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d_core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst got=%0b exp=1", d_core_rst); end
    checks++; if (d_run_active !== 1'b0) begin errors++; $display("FAIL rst_run_active got=%0b exp=0", d_run_active); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", d_done); end
    checks++; if (d_pass !== 1'b0) begin errors++; $display("FAIL rst_pass got=%0b exp=0", d_pass); end
    checks++; if (d_last_led !== 8'h00) begin errors++; $display("FAIL rst_last_led got=%0h exp=0", d_last_led); end
    checks++; if (d_cycle_cnt !== 16'd0) begin errors++; $display("FAIL rst_cycle_cnt got=%0d exp=0", d_cycle_cnt); end
    checks++; if (d_run_idx !== 2'd0) begin errors++; $display("FAIL rst_run_idx got=%0d exp=0", d_run_idx); end
    checks++; if (d_led_changes !== 16'd0) begin errors++; $display("FAIL rst_led_changes got=%0d exp=0", d_led_changes); end
    rst = 1'b0;
  endtask

  task automatic test_default();
    int n;
    @(negedge clk); d_led = 8'h00; d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    count_level(0, 1'b1, 20, n);
    checks++; if (n != 12) begin errors++; $display("FAIL def_hold0 got=%0d exp=12", n); end
    count_level(0, 1'b0, 1100, n);
    checks++; if (n != 1000) begin errors++; $display("FAIL def_run0 got=%0d exp=1000", n); end
    count_level(0, 1'b1, 20, n);
    checks++; if (n != 12) begin errors++; $display("FAIL def_hold1 got=%0d exp=12", n); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL def_done_in_run got=%0b exp=0", d_done); end
    count_level(0, 1'b0, 1100, n);
    checks++; if (n != 1000) begin errors++; $display("FAIL def_run1 got=%0d exp=1000", n); end
    checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL def_done got=%0b exp=1", d_done); end
    checks++; if (d_pass !== 1'b1) begin errors++; $display("FAIL def_pass got=%0b exp=1", d_pass); end
    checks++; if (d_run_idx !== 2'd1) begin errors++; $display("FAIL def_run_idx got=%0d exp=1", d_run_idx); end
    checks++; if (d_cycle_cnt !== 16'd1000) begin errors++; $display("FAIL def_cycle_cnt got=%0d exp=1000", d_cycle_cnt); end
    checks++; if (d_led_changes !== 16'd0) begin errors++; $display("FAIL def_led_changes got=%0d exp=0", d_led_changes); end
    checks++; if (d_run_active !== 1'b0) begin errors++; $display("FAIL def_run_active got=%0b exp=0", d_run_active); end
  endtask

  task automatic test_halt_short();
    int n;
    logic [7:0] val;
    for (int i = 0; i < 2; i++) begin
      val = (i == 0) ? 8'h00 : 8'hA5;
      @(negedge clk); s_led = val; s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL short_done_clear[%0d] got=%0b exp=0", i, s_done); end
      n = 0;
      while (!s_run_active && n < 50) begin n++; @(negedge clk); end
      checks++; if (n != 12) begin errors++; $display("FAIL short_hold_len[%0d] got=%0d exp=12", i, n); end
      repeat (19) @(negedge clk);
      checks++; if (s_cycle_cnt !== 16'd19) begin errors++; $display("FAIL short_cnt_pre[%0d] got=%0d exp=19", i, s_cycle_cnt); end
      s_halt = 1'b1;
      @(negedge clk); s_halt = 1'b0;
      checks++; if (s_cycle_cnt !== 16'd20) begin errors++; $display("FAIL short_cnt[%0d] got=%0d exp=20", i, s_cycle_cnt); end
      checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL short_done[%0d] got=%0b exp=1", i, s_done); end
      checks++; if (s_pass !== (val == 8'h00)) begin errors++; $display("FAIL short_pass[%0d] got=%0b exp=%0b", i, s_pass, (val == 8'h00)); end
      checks++; if (s_last_led !== val) begin errors++; $display("FAIL short_last_led[%0d] got=%0h exp=%0h", i, s_last_led, val); end
      checks++; if (s_core_rst !== 1'b1) begin errors++; $display("FAIL short_core_rst[%0d] got=%0b exp=1", i, s_core_rst); end
    end
  endtask

  task automatic test_saturate();
    int n;
    int k;
    @(negedge clk); t_led = 8'h00; t_start = 1'b1;
    @(negedge clk); t_start = 1'b0;
    n = 0; k = 0;
    while (!t_done && n < 300) begin
      if (t_run_active) begin
        k++;
        if (k == 11) begin
          checks++; if (t_led_changes !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d exp=10", t_led_changes); end
        end
        if (k == 17) begin
          checks++; if (t_led_changes !== 4'd15) begin errors++; $display("FAIL sat_edge got=%0d exp=15", t_led_changes); end
        end
      end
      t_led = ~t_led;
      n++;
      @(negedge clk);
    end
    checks++; if (t_done !== 1'b1) begin errors++; $display("FAIL sat_done got=%0b exp=1 (timeout)", t_done); end
    checks++; if (k != 80) begin errors++; $display("FAIL sat_run_cycles got=%0d exp=80", k); end
    checks++; if (t_led_changes !== 4'd15) begin errors++; $display("FAIL sat_final got=%0d exp=15", t_led_changes); end
    checks++; if (t_run_idx !== 2'd1) begin errors++; $display("FAIL sat_run_idx got=%0d exp=1", t_run_idx); end
  endtask

  task automatic test_abort();
    int n;
    int bad;
    @(negedge clk); d_led = 8'h00; d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    n = 0;
    while (!(d_run_active && d_run_idx == 2'd1) && n < 1200) begin n++; @(negedge clk); end
    checks++; if (n >= 1200) begin errors++; $display("FAIL abort_wait_run1 got=timeout exp=run1"); end
    repeat (4) @(negedge clk);
    d_abort = 1'b1; d_halt = 1'b1;
    @(negedge clk); d_abort = 1'b0; d_halt = 1'b0;
    checks++; if (d_core_rst !== 1'b1) begin errors++; $display("FAIL abort_core_rst got=%0b exp=1", d_core_rst); end
    checks++; if (d_run_active !== 1'b0) begin errors++; $display("FAIL abort_run_active got=%0b exp=0", d_run_active); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%0b exp=0", d_done); end
    checks++; if (d_pass !== 1'b0) begin errors++; $display("FAIL abort_pass got=%0b exp=0", d_pass); end
    checks++; if (d_run_idx !== 2'd1) begin errors++; $display("FAIL abort_run_idx got=%0d exp=1", d_run_idx); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (d_core_rst !== 1'b1 || d_run_active !== 1'b0 || d_done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_idle got=%0d bad cycles exp=0", bad); end
    d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    count_level(0, 1'b1, 20, n);
    checks++; if (n != 12) begin errors++; $display("FAIL abort_re_hold0 got=%0d exp=12", n); end
    count_level(0, 1'b0, 1100, n);
    checks++; if (n != 1000) begin errors++; $display("FAIL abort_re_run0 got=%0d exp=1000", n); end
    count_level(0, 1'b1, 20, n);
    checks++; if (n != 12) begin errors++; $display("FAIL abort_re_hold1 got=%0d exp=12", n); end
    count_level(0, 1'b0, 1100, n);
    checks++; if (n != 1000) begin errors++; $display("FAIL abort_re_run1 got=%0d exp=1000", n); end
    checks++; if (d_done !== 1'b1 || d_pass !== 1'b1) begin errors++; $display("FAIL abort_re_verdict got=%0b%0b exp=11", d_done, d_pass); end
    checks++; if (d_cycle_cnt !== 16'd1000) begin errors++; $display("FAIL abort_re_cycle_cnt got=%0d exp=1000", d_cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk); r_led = 8'h11; r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    n = 0;
    while (!r_run_active && n < 10) begin n++; @(negedge clk); end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_hold0 got=%0d exp=3", n); end
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      r_start = (k == 7);
      r_halt = (k == 20);
    end
    @(negedge clk); r_halt = 1'b0; r_start = 1'b0;
    checks++; if (r_run_idx !== 2'd1) begin errors++; $display("FAIL b2b_run_idx got=%0d exp=1", r_run_idx); end
    checks++; if (r_cycle_cnt !== 5'd20) begin errors++; $display("FAIL b2b_cycle_cnt got=%0d exp=20", r_cycle_cnt); end
    checks++; if (r_core_rst !== 1'b1 || r_run_active !== 1'b0) begin errors++; $display("FAIL b2b_end got=%0b%0b exp=10", r_core_rst, r_run_active); end
    r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    count_level(1, 1'b1, 10, n);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_hold1_rest got=%0d exp=2", n); end
    count_level(1, 1'b0, 30, n);
    checks++; if (n != 20) begin errors++; $display("FAIL b2b_run1 got=%0d exp=20", n); end
    checks++; if (r_run_idx !== 2'd2) begin errors++; $display("FAIL b2b_run_idx2 got=%0d exp=2", r_run_idx); end
    r_abort = 1'b1;
    @(negedge clk); r_abort = 1'b0;
    checks++; if (r_core_rst !== 1'b1 || r_done !== 1'b0 || r_run_active !== 1'b0) begin errors++; $display("FAIL b2b_abort got=%0b%0b%0b exp=100", r_core_rst, r_done, r_run_active); end
    checks++; if (r_run_idx !== 2'd2) begin errors++; $display("FAIL b2b_abort_idx got=%0d exp=2", r_run_idx); end
  endtask

  // Reference: each run lasts min(halt cycle, budget); changes are counted from
  // the LED history starting with the final HOLD value; verdict uses the last value.
  task automatic test_random();
    int halt_at[3];
    int len, changes, exp_chg, hold_bad, run_bad;
    logic [7:0] v, prev, hold_led;
    logic force_pass, exp_pass;
    for (int seq = 0; seq < 6; seq++) begin
      for (int r = 0; r < 3; r++) halt_at[r] = $urandom_range(1, 24);
      force_pass = $urandom_range(0, 1);
      changes = 0;
      v = 8'h00;
      @(negedge clk); r_start = 1'b1; r_led = 8'($urandom); r_halt = $urandom_range(0, 1);
      @(negedge clk); r_start = 1'b0;
      for (int r = 0; r < 3; r++) begin
        hold_led = 8'($urandom);
        hold_bad = 0;
        for (int c = 1; c <= 3; c++) begin
          if (c > 1) @(negedge clk);
          if (r_core_rst !== 1'b1 || r_run_active !== 1'b0) hold_bad++;
          r_led = hold_led; r_halt = $urandom_range(0, 1); r_start = $urandom_range(0, 1);
        end
        prev = hold_led;
        len = (halt_at[r] > 20) ? 20 : halt_at[r];
        run_bad = 0;
        for (int k = 1; k <= len; k++) begin
          @(negedge clk);
          if (r_core_rst !== 1'b0 || r_run_active !== 1'b1 || r_run_idx !== 2'(r)) run_bad++;
          v = 8'($urandom);
          if ($urandom_range(0, 2) == 0) v = prev;
          if (r == 2 && k == len && force_pass) v = 8'h3C;
          r_led = v; r_halt = (k == halt_at[r]); r_start = $urandom_range(0, 1);
          if (v != prev) changes++;
          prev = v;
        end
        @(negedge clk); r_halt = 1'b0; r_start = 1'b0;
        exp_chg = (changes > 31) ? 31 : changes;
        exp_pass = (r == 2) && (v == 8'h3C);
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL rnd_hold s%0d r%0d got=%0d bad exp=0", seq, r, hold_bad); end
        checks++; if (run_bad != 0) begin errors++; $display("FAIL rnd_run s%0d r%0d got=%0d bad exp=0", seq, r, run_bad); end
        checks++; if (r_cycle_cnt !== 5'(len)) begin errors++; $display("FAIL rnd_cycle_cnt s%0d r%0d got=%0d exp=%0d", seq, r, r_cycle_cnt, len); end
        checks++; if (r_last_led !== v) begin errors++; $display("FAIL rnd_last_led s%0d r%0d got=%0h exp=%0h", seq, r, r_last_led, v); end
        checks++; if (r_led_changes !== 5'(exp_chg)) begin errors++; $display("FAIL rnd_led_changes s%0d r%0d got=%0d exp=%0d", seq, r, r_led_changes, exp_chg); end
        checks++; if (r_run_idx !== 2'((r < 2) ? r + 1 : 2)) begin errors++; $display("FAIL rnd_run_idx s%0d r%0d got=%0d", seq, r, r_run_idx); end
        checks++; if (r_done !== (r == 2)) begin errors++; $display("FAIL rnd_done s%0d r%0d got=%0b exp=%0b", seq, r, r_done, (r == 2)); end
        checks++; if (r_pass !== exp_pass) begin errors++; $display("FAIL rnd_pass s%0d r%0d got=%0b exp=%0b", seq, r, r_pass, exp_pass); end
      end
    end
  endtask

  task automatic test_rst_mid_hold();
    int n;
    int bad;
    @(negedge clk); r_led = 8'h00; r_start = 1'b1;
    @(negedge clk); r_start = 1'b0;
    n = 0;
    while (!r_run_active && n < 10) begin n++; @(negedge clk); end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      r_led = (k % 2 == 1) ? 8'h5A : 8'h00;
      r_halt = (k == 5);
    end
    @(negedge clk); r_halt = 1'b0;
    checks++; if (r_last_led !== 8'h5A || r_run_idx !== 2'd1) begin errors++; $display("FAIL rstm_setup got=%0h/%0d exp=5a/1", r_last_led, r_run_idx); end
    @(negedge clk); rst = 1'b1; r_start = 1'b1;
    @(negedge clk); rst = 1'b0; r_start = 1'b0;
    checks++; if (r_core_rst !== 1'b1) begin errors++; $display("FAIL rstm_core_rst got=%0b exp=1", r_core_rst); end
    checks++; if (r_run_active !== 1'b0 || r_done !== 1'b0 || r_pass !== 1'b0) begin errors++; $display("FAIL rstm_flags got=%0b%0b%0b exp=000", r_run_active, r_done, r_pass); end
    checks++; if (r_last_led !== 8'h00) begin errors++; $display("FAIL rstm_last_led got=%0h exp=0", r_last_led); end
    checks++; if (r_cycle_cnt !== 5'd0) begin errors++; $display("FAIL rstm_cycle_cnt got=%0d exp=0", r_cycle_cnt); end
    checks++; if (r_run_idx !== 2'd0) begin errors++; $display("FAIL rstm_run_idx got=%0d exp=0", r_run_idx); end
    checks++; if (r_led_changes !== 5'd0) begin errors++; $display("FAIL rstm_led_changes got=%0d exp=0", r_led_changes); end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (r_core_rst !== 1'b1 || r_run_active !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstm_start_ignored got=%0d bad cycles exp=0", bad); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    d_start = 0; d_abort = 0; d_halt = 0; d_led = 8'h00;
    s_start = 0; s_abort = 0; s_halt = 0; s_led = 8'h00;
    t_start = 0; t_abort = 0; t_halt = 0; t_led = 8'h00;
    r_start = 0; r_abort = 0; r_halt = 0; r_led = 8'h00;
    test_reset();
    test_default();
    test_halt_short();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_random();
    test_rst_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
